adaptive_phase_scheduler: RTL and testbench
===========================================

Name: adaptive_phase_scheduler

Overview:
Parametrised day-time signal scheduler for an N-direction intersection. It sums per-lane vehicle counts for each direction and gives green to the busiest direction, never the one just served. The green time scales with that direction's queue. It sequences GREEN -> YELLOW -> ALL_RED on a 1 Hz tick and drives the per-lane light enables consumed by the light driver stage.

Parameters:
NUM_DIRS, 4, number of approach directions (>=2)
LANES_PER_DIR, 2, lanes per direction
COUNT_W, 8, width of each lane count
TIME_W, 7, width of phase timer
BASE_GREEN, 20, minimum green ticks
MAX_GREEN, 60, green saturation limit (BASE_GREEN<=MAX_GREEN<2^TIME_W)
GREEN_SHIFT, 2, queue-to-time scaling: extra = sum >> GREEN_SHIFT
YELLOW_TIME, 3, yellow ticks (>=1)
ALL_RED_TIME, 1, all-red ticks (>=1)
MAX_SKIP, 3, starvation limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1 Hz time-base pulse
en  in  1  scheduler enable; low freezes timer and state
lane_count  in  NUM_DIRS*LANES_PER_DIR*COUNT_W  packed counts; lane l of direction d at index d*LANES_PER_DIR+l
lane_green  out  NUM_DIRS*LANES_PER_DIR  green enables, same lane ordering
lane_yellow  out  NUM_DIRS*LANES_PER_DIR  yellow enables
phase  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW
active_dir  out  clog2(NUM_DIRS)  direction currently or last served
timer_val  out  TIME_W  remaining ticks in current phase
phase_done  out  1  one-cycle pulse on every phase transition

Behaviour:
- Single clk domain. rst_n is asynchronous and active-low. Reset values: phase=ALL_RED, timer_val=ALL_RED_TIME, active_dir=0, lane_green=0, lane_yellow=0, phase_done=0. prev_valid=0, so the first selection excludes no direction.
- Time advances only on cycles where tick&&en. With en low, all state holds, including across ticks.
- The timer is loaded with phase duration D and decrements on each qualified tick. On the qualified tick where timer_val==1, the FSM transitions on that edge, loads the next duration, and pulses phase_done for one cycle. Each phase therefore lasts exactly D ticks. timer_val never reads 0.
- FSM: ALL_RED -> GREEN -> YELLOW -> ALL_RED.
- Direction selection is combinational on lane_count at the ALL_RED-exit tick; the result is registered into active_dir on that edge.
  - sum_d = sum of direction d's lane counts, width COUNT_W+clog2(LANES_PER_DIR), no overflow.
  - Eligible = all d except active_dir when prev_valid=1.
  - Pick max sum_d among eligible; ties go to the lowest index.
  - If all eligible sums are 0, pick (active_dir+1) mod NUM_DIRS.
  - prev_valid is set on the first selection.
- Green duration = min(BASE_GREEN + (sum_sel >> GREEN_SHIFT), MAX_GREEN). The addition is computed wide enough to avoid wrap before saturation. sum_sel is the sum captured at selection; count changes during GREEN do not alter the duration.
- YELLOW loads YELLOW_TIME. ALL_RED loads ALL_RED_TIME.
- lane_green bits for active_dir are all 1 only in GREEN; lane_yellow bits likewise only in YELLOW. Both are 0 in ALL_RED. Outputs are registered, and green and yellow are never both set.
- Reset mid-phase returns immediately to the reset state, with lights off.

Optional Feature:
STARVATION_GUARD_EN
- Defined:
  - Each direction has a skip counter (clog2(MAX_SKIP+1) bits).
  - At each selection, every eligible, non-selected direction with sum_d>0 increments its counter, saturating at MAX_SKIP. The selected direction's counter clears.
  - If any eligible direction's counter == MAX_SKIP, the lowest such index is selected, overriding the max rule. Green duration still uses its own sum.
  - Counters reset to 0.
- Undefined: no counters; pure max rule.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> lane_green=0, lane_yellow=0, phase=00, timer_val=1, active_dir=0 asynchronously.
- Basic select: counts N=10,10 E=50,30 S=0,0 W=5,0; one tick after reset -> active_dir=1, phase=01, timer_val=40, lane_green=8'b00001100, phase_done pulse.
  - After 40 ticks -> phase=10, lane_yellow=8'b00001100, timer_val=3.
  - 3 ticks later -> ALL_RED, timer_val=1.
  - Next tick -> active_dir=0 (E excluded).
- Saturation and tie: E=255,255 -> green timer_val=60. N=S=40 with E served -> N (index 0) chosen.
- All-zero and en: all counts 0 with active_dir=3 -> next active_dir=0, green 20. Drop en for 10 ticks mid-GREEN -> timer_val unchanged, no phase_done.
- Reset mid-GREEN at timer_val=12 -> lights off, phase=00, timer_val=1. The next selection may pick the previously active direction.
- With STARVATION_GUARD_EN: E=200,200, N=100,100, S=W=1,0 (ordering stable).
  - S counter reaches 3 after three of its skipped selections.
  - At the next selection where S is eligible, S is forced and gets green 20 despite lower sum.
  - Without the macro, S is never chosen in that sequence.

Source files
------------

// File: rtl/adaptive_phase_scheduler.sv
// adaptive_phase_scheduler: busiest-direction traffic scheduler with queue-scaled green time.
// Define STARVATION_GUARD_EN to force service of directions skipped MAX_SKIP times.
module adaptive_phase_scheduler #(
    parameter int NUM_DIRS      = 4,
    parameter int LANES_PER_DIR = 2,
    parameter int COUNT_W       = 8,
    parameter int TIME_W        = 7,
    parameter int BASE_GREEN    = 20,
    parameter int MAX_GREEN     = 60,
    parameter int GREEN_SHIFT   = 2,
    parameter int YELLOW_TIME   = 3,
    parameter int ALL_RED_TIME  = 1,
    parameter int MAX_SKIP      = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      tick,
    input  logic                                      en,
    input  logic [NUM_DIRS*LANES_PER_DIR*COUNT_W-1:0] lane_count,
    output logic [NUM_DIRS*LANES_PER_DIR-1:0]         lane_green,
    output logic [NUM_DIRS*LANES_PER_DIR-1:0]         lane_yellow,
    output logic [1:0]                                phase,
    output logic [$clog2(NUM_DIRS)-1:0]               active_dir,
    output logic [TIME_W-1:0]                         timer_val,
    output logic                                      phase_done
);
    localparam int NL    = NUM_DIRS * LANES_PER_DIR;
    localparam int DIR_W = $clog2(NUM_DIRS);
    localparam int SUM_W = COUNT_W + $clog2(LANES_PER_DIR);
    localparam int GW    = SUM_W + TIME_W + 1;

    typedef enum logic [1:0] {ALL_RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} state_t;

    state_t             r_state;
    logic [TIME_W-1:0]  r_timer;
    logic [DIR_W-1:0]   r_dir;
    logic               r_prev_valid;
    logic [NL-1:0]      r_green;
    logic [NL-1:0]      r_yellow;
    logic               r_done;

    logic [SUM_W-1:0]   w_sum [NUM_DIRS];
    logic [NUM_DIRS-1:0] w_elig;
    logic [SUM_W-1:0]   w_best;
    logic               w_found;
    logic [DIR_W-1:0]   w_max_dir;
    logic [DIR_W-1:0]   w_next_dir;
    logic [DIR_W-1:0]   w_sel_max;
    logic [DIR_W-1:0]   w_sel;
    logic [SUM_W-1:0]   w_sel_sum;
    logic [GW-1:0]      w_green_wide;
    logic [TIME_W-1:0]  w_green_time;
    logic [NL-1:0]      w_mask_sel;
    logic [NL-1:0]      w_mask_act;
    logic               w_step;

    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++) begin
            w_sum[d] = '0;
            for (int l = 0; l < LANES_PER_DIR; l++)
                w_sum[d] = w_sum[d] + SUM_W'(lane_count[(d*LANES_PER_DIR+l)*COUNT_W +: COUNT_W]);
            w_elig[d] = !(r_prev_valid && r_dir == DIR_W'(d));
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        w_best    = '0;
        w_found   = 1'b0;
        w_max_dir = '0;
        for (int d = 0; d < NUM_DIRS; d++)
            if (w_elig[d] && (!w_found || w_sum[d] > w_best)) begin
                w_found   = 1'b1;
                w_best    = w_sum[d];
                w_max_dir = DIR_W'(d);
            end
    end

    assign w_next_dir = (r_dir == DIR_W'(NUM_DIRS-1)) ? '0 : r_dir + 1'b1;
    assign w_sel_max  = (w_best == '0) ? w_next_dir : w_max_dir;

`ifdef STARVATION_GUARD_EN
    localparam int SKW = $clog2(MAX_SKIP+1);
    logic [SKW-1:0]   r_skip [NUM_DIRS];
    logic             w_forced;
    logic [DIR_W-1:0] w_force_dir;

    always_comb begin
        w_forced    = 1'b0;
        w_force_dir = '0;
        for (int d = NUM_DIRS-1; d >= 0; d--)
            if (w_elig[d] && r_skip[d] == SKW'(MAX_SKIP)) begin
                w_forced    = 1'b1;
                w_force_dir = DIR_W'(d);
            end
    end

    assign w_sel = w_forced ? w_force_dir : w_sel_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DIRS; d++) r_skip[d] <= '0;
        end else if (w_step && r_state == ALL_RED) begin
            for (int d = 0; d < NUM_DIRS; d++)
                if (w_sel == DIR_W'(d))
                    r_skip[d] <= '0;
                else if (w_elig[d] && w_sum[d] != '0 && r_skip[d] != SKW'(MAX_SKIP))
                    r_skip[d] <= r_skip[d] + 1'b1;
        end
    end
`else
    assign w_sel = w_sel_max;
`endif

    assign w_sel_sum    = w_sum[w_sel];
    assign w_green_wide = GW'(BASE_GREEN) + GW'(w_sel_sum >> GREEN_SHIFT);
    assign w_green_time = (w_green_wide > GW'(MAX_GREEN)) ? TIME_W'(MAX_GREEN) : w_green_wide[TIME_W-1:0];

    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++)
            for (int l = 0; l < LANES_PER_DIR; l++) begin
                w_mask_sel[d*LANES_PER_DIR+l] = (w_sel == DIR_W'(d));
                w_mask_act[d*LANES_PER_DIR+l] = (r_dir == DIR_W'(d));
            end
    end

    assign w_step = tick && en && r_timer == TIME_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ALL_RED;
            r_timer      <= TIME_W'(ALL_RED_TIME);
            r_dir        <= '0;
            r_prev_valid <= 1'b0;
            r_green      <= '0;
            r_yellow     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_step) begin
                r_done <= 1'b1;
                case (r_state)
                    ALL_RED: begin
                        r_state      <= GREEN;
                        r_timer      <= w_green_time;
                        r_dir        <= w_sel;
                        r_prev_valid <= 1'b1;
                        r_green      <= w_mask_sel;
                        r_yellow     <= '0;
                    end
                    GREEN: begin
                        r_state  <= YELLOW;
                        r_timer  <= TIME_W'(YELLOW_TIME);
                        r_green  <= '0;
                        r_yellow <= w_mask_act;
                    end
                    default: begin
                        r_state  <= ALL_RED;
                        r_timer  <= TIME_W'(ALL_RED_TIME);
                        r_green  <= '0;
                        r_yellow <= '0;
                    end
                endcase
            end else if (tick && en) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    assign lane_green  = r_green;
    assign lane_yellow = r_yellow;
    assign phase       = r_state;
    assign active_dir  = r_dir;
    assign timer_val   = r_timer;
    assign phase_done  = r_done;
endmodule

// File: tb/tb_adaptive_phase_scheduler.sv
// tb_adaptive_phase_scheduler: directed scoreboard bench; expected transitions are queued
// by the stimulus and popped by a monitor on every phase_done pulse.
module tb_adaptive_phase_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        en;
    logic [63:0] lane_count;
    logic [7:0]  lane_green;
    logic [7:0]  lane_yellow;
    logic [1:0]  phase;
    logic [1:0]  active_dir;
    logic [6:0]  timer_val;
    logic        phase_done;

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] dir;
        logic [6:0] tm;
        logic [7:0] g;
        logic [7:0] y;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    adaptive_phase_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .lane_count(lane_count),
        .lane_green(lane_green), .lane_yellow(lane_yellow), .phase(phase),
        .active_dir(active_dir), .timer_val(timer_val), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (rst_n && phase_done) begin
            checks++;
            a = '{phase, active_dir, timer_val, lane_green, lane_yellow};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_phase_done got %h want none", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL transition got ph=%b dir=%0d tm=%0d g=%b y=%b want ph=%b dir=%0d tm=%0d g=%b y=%b",
                             a.ph, a.dir, a.tm, a.g, a.y, e.ph, e.dir, e.tm, e.g, e.y);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic expect_t(input logic [1:0] ph, input logic [1:0] dir, input int tm,
                            input logic [7:0] g, input logic [7:0] y);
        q.push_back('{ph, dir, 7'(tm), g, y});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic set_cnt(input logic [7:0] n0, n1, e0, e1, s0, s1, w0, w1);
        lane_count = {w1, w0, s1, s0, e1, e0, n1, n0};
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_green"}, lane_green, 0);
        chk({tag, "_yellow"}, lane_yellow, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_timer"}, timer_val, 1);
        chk({tag, "_dir"}, active_dir, 0);
        chk({tag, "_done"}, phase_done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        en    = 1'b1;
        set_cnt(10, 10, 50, 30, 0, 0, 5, 0);
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        // E busiest: 20 + 80/4 = 40, then N with E excluded: 20 + 20/4 = 25
        expect_t(2'b01, 1, 40, 8'b00001100, 8'h00);
        ticks(1);
        chk("green_timer", timer_val, 40);
        expect_t(2'b10, 1, 3, 8'h00, 8'b00001100);
        expect_t(2'b00, 1, 1, 8'h00, 8'h00);
        expect_t(2'b01, 0, 25, 8'b00000011, 8'h00);
        ticks(44);

        // saturation: E sum 510 -> 60
        set_cnt(0, 0, 255, 255, 0, 0, 0, 0);
        expect_t(2'b10, 0, 3, 8'h00, 8'b00000011);
        expect_t(2'b00, 0, 1, 8'h00, 8'h00);
        expect_t(2'b01, 1, 60, 8'b00001100, 8'h00);
        ticks(29);

        // tie N=S=40 with E excluded -> N, 20 + 10 = 30
        set_cnt(20, 20, 255, 255, 30, 10, 0, 0);
        expect_t(2'b10, 1, 3, 8'h00, 8'b00001100);
        expect_t(2'b00, 1, 1, 8'h00, 8'h00);
        expect_t(2'b01, 0, 30, 8'b00000011, 8'h00);
        ticks(64);

        set_cnt(0, 0, 0, 0, 0, 0, 4, 0);
        expect_t(2'b10, 0, 3, 8'h00, 8'b00000011);
        expect_t(2'b00, 0, 1, 8'h00, 8'h00);
        expect_t(2'b01, 3, 21, 8'b11000000, 8'h00);
        ticks(34);

        // all zero after W -> wraps to N with base green
        set_cnt(0, 0, 0, 0, 0, 0, 0, 0);
        expect_t(2'b10, 3, 3, 8'h00, 8'b11000000);
        expect_t(2'b00, 3, 1, 8'h00, 8'h00);
        expect_t(2'b01, 0, 20, 8'b00000011, 8'h00);
        ticks(25);

        ticks(5);
        chk("pre_freeze_timer", timer_val, 15);
        en = 1'b0;
        ticks(10);
        chk("freeze_timer", timer_val, 15);
        chk("freeze_phase", phase, 1);
        en = 1'b1;
        ticks(3);
        chk("resume_timer", timer_val, 12);

        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk) rst_n = 1'b1;

        // no previous direction after reset: N may be picked again, 20 + 8/4 = 22
        set_cnt(8, 0, 0, 0, 0, 0, 0, 0);
        expect_t(2'b01, 0, 22, 8'b00000011, 8'h00);
        ticks(1);

        // heavy N/E alternate; S never chosen by the max rule
        set_cnt(100, 100, 200, 200, 1, 0, 1, 0);
        expect_t(2'b10, 0, 3, 8'h00, 8'b00000011);
        expect_t(2'b00, 0, 1, 8'h00, 8'h00);
        expect_t(2'b01, 1, 60, 8'b00001100, 8'h00);
        expect_t(2'b10, 1, 3, 8'h00, 8'b00001100);
        expect_t(2'b00, 1, 1, 8'h00, 8'h00);
        expect_t(2'b01, 0, 60, 8'b00000011, 8'h00);
        expect_t(2'b10, 0, 3, 8'h00, 8'b00000011);
        expect_t(2'b00, 0, 1, 8'h00, 8'h00);
        expect_t(2'b01, 1, 60, 8'b00001100, 8'h00);
        ticks(154);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
